// File: rtl/rgb2raw_8.sv
// RGB to 8-bit Bayer RAW mosaicing: one 24-bit pixel per accept, one 16-bit
// word (even-column byte, odd-column byte) per column pair, fixed idle gap after each line.
module rgb2raw_8 #(
  parameter int LINE_LENGTH = 640,
  parameter int FRAME_LINES = 480,
  parameter int LINE_GAP    = 4,
  parameter bit INVERT_RG   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] rgb_in,
  input  logic        rgb_valid,
  input  logic        rgb_sof,
  output logic        rgb_ready,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        line_end,
  output logic        frame_end,
  output logic        sof_err
);

  localparam int PIX_PER_LINE = 2 * LINE_LENGTH;
  localparam int CW = (PIX_PER_LINE > 1) ? $clog2(PIX_PER_LINE) : 1;
  localparam int RW = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
  localparam int GW = $clog2(LINE_GAP + 1);

  localparam logic [CW-1:0] COL_LAST = CW'(PIX_PER_LINE - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_LINES - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(LINE_GAP);
  localparam logic [7:0]    RG_MASK  = INVERT_RG ? 8'hFF : 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [GW-1:0]   gap_cnt;
  logic [7:0]      hold;

  logic [7:0]      r_byte;
  logic [7:0]      g_byte;
  logic [7:0]      b_byte;
  logic [7:0]      sel_byte;
  logic            accept;

  // A pixel transfers on any cycle where rgb_valid and rgb_ready are both high;
  // the RAW side has no backpressure, data_valid is a single-cycle strobe.
  assign rgb_ready = (state != ST_GAP);
  assign accept    = rgb_valid & rgb_ready;

  assign r_byte = rgb_in[23:16] ^ RG_MASK;
  assign g_byte = rgb_in[15:8]  ^ RG_MASK;
  assign b_byte = rgb_in[7:0];

  // Bayer site: even rows are G/B, odd rows are R/G.
  always_comb begin
    sel_byte = g_byte;
    case ({row[0], col[0]})
      2'b00:   sel_byte = g_byte;
      2'b01:   sel_byte = b_byte;
      2'b10:   sel_byte = r_byte;
      default: sel_byte = g_byte;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      col        <= '0;
      row        <= '0;
      gap_cnt    <= '0;
      hold       <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      line_end   <= 1'b0;
      frame_end  <= 1'b0;
      sof_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      line_end   <= 1'b0;
      frame_end  <= 1'b0;
      sof_err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept && rgb_sof) begin
            hold  <= g_byte;
            col   <= CW'(1);
            row   <= '0;
            state <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (accept) begin
            if (rgb_sof) begin
              // Restart: the partial line and held byte are abandoned.
              sof_err <= 1'b1;
              hold    <= g_byte;
              col     <= CW'(1);
              row     <= '0;
            end else if (!col[0]) begin
              hold <= sel_byte;
              col  <= col + 1'b1;
            end else begin
              data_out   <= {hold, sel_byte};
              data_valid <= 1'b1;
              if (col == COL_LAST) begin
                col      <= '0;
                line_end <= 1'b1;
                gap_cnt  <= GAP_LOAD;
                state    <= ST_GAP;
                if (row == ROW_LAST) begin
                  frame_end <= 1'b1;
                  row       <= '0;
                end else begin
                  row <= row + 1'b1;
                end
              end else begin
                col <= col + 1'b1;
              end
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == GW'(1)) begin
            // Row only reads zero here after the frame's last line wrapped it.
            state <= (row == '0) ? ST_IDLE : ST_ACTIVE;
          end
          gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb2raw_8.sv
// Bench for rgb2raw_8: two instances (INVERT_RG=0/1) share one stimulus stream and
// are checked each cycle against a line-buffer model plus hand-computed word lists.
module tb_rgb2raw_8;

  localparam int LL  = 4;
  localparam int FL  = 2;
  localparam int GAP = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] rgb_in = '0;
  logic        rgb_valid = 1'b0;
  logic        rgb_sof = 1'b0;

  logic        rdy0, rdy1;
  logic [15:0] data0, data1;
  logic        dv0, dv1, le0, le1, fe0, fe1, se0, se1;

  int checks = 0;
  int failures = 0;

  rgb2raw_8 #(.LINE_LENGTH(LL), .FRAME_LINES(FL), .LINE_GAP(GAP), .INVERT_RG(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .rgb_in(rgb_in), .rgb_valid(rgb_valid), .rgb_sof(rgb_sof),
    .rgb_ready(rdy0), .data_out(data0), .data_valid(dv0), .line_end(le0),
    .frame_end(fe0), .sof_err(se0)
  );

  rgb2raw_8 #(.LINE_LENGTH(LL), .FRAME_LINES(FL), .LINE_GAP(GAP), .INVERT_RG(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .rgb_in(rgb_in), .rgb_valid(rgb_valid), .rgb_sof(rgb_sof),
    .rgb_ready(rdy1), .data_out(data1), .data_valid(dv1), .line_end(le1),
    .frame_end(fe1), .sof_err(se1)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: sim time expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model collects the pixels of the current line; every completed pair becomes a word.
  logic [23:0] m_pix[$];
  int          m_row = 0;
  int          m_gap = 0;
  bit          m_in_frame = 0;
  logic [15:0] e_data[2] = '{16'h0, 16'h0};
  bit          e_dv = 0, e_le = 0, e_fe = 0, e_serr = 0, e_rdy = 1;

  function automatic logic [7:0] byte_of(input logic [23:0] p, input int row, input int col,
                                         input int inv);
    int ch_tab[2][2] = '{'{1, 2}, '{0, 1}};  // 0=R 1=G 2=B
    logic [7:0] r, g, b;
    r = (inv != 0) ? ~p[23:16] : p[23:16];
    g = (inv != 0) ? ~p[15:8]  : p[15:8];
    b = p[7:0];
    case (ch_tab[row % 2][col % 2])
      0:       return r;
      1:       return g;
      default: return b;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pix.delete();
      m_row = 0; m_gap = 0; m_in_frame = 0;
      e_data = '{16'h0, 16'h0};
      e_dv = 0; e_le = 0; e_fe = 0; e_serr = 0; e_rdy = 1;
    end else begin
      bit pushed;
      int n;
      pushed = 0;
      e_dv = 0; e_le = 0; e_fe = 0; e_serr = 0;
      if (m_gap > 0) begin
        m_gap--;
      end else if (rgb_valid) begin
        if (rgb_sof) begin
          if (m_in_frame) e_serr = 1;
          m_pix.delete();
          m_row = 0;
          m_in_frame = 1;
          m_pix.push_back(rgb_in);
          pushed = 1;
        end else if (m_in_frame) begin
          m_pix.push_back(rgb_in);
          pushed = 1;
        end
        n = m_pix.size();
        if (pushed && (n % 2 == 0)) begin
          for (int d = 0; d < 2; d++)
            e_data[d] = {byte_of(m_pix[n-2], m_row, n-2, d), byte_of(m_pix[n-1], m_row, n-1, d)};
          e_dv = 1;
          if (n == 2 * LL) begin
            e_le = 1;
            m_gap = GAP;
            m_pix.delete();
            if (m_row == FL - 1) begin
              e_fe = 1;
              m_row = 0;
              m_in_frame = 0;
            end else begin
              m_row++;
            end
          end
        end
      end
      e_rdy = (m_gap == 0);
    end
  end

  // ---------------- scoreboard with literal expected words ----------------
  logic [17:0] exp_q0[$];
  logic [17:0] exp_q1[$];

  task automatic push_exp(input logic [15:0] w0, input logic [15:0] w1, input bit le, input bit fe);
    exp_q0.push_back({le, fe, w0});
    exp_q1.push_back({le, fe, w1});
  endtask

  bit cnt_en = 0;
  int rdy_low_cnt = 0;
  int dv_cnt = 0;
  int serr_cnt0 = 0;
  int serr_cnt1 = 0;

  always @(negedge clk) begin
    check("model_dv0", dv0, e_dv);
    check("model_dv1", dv1, e_dv);
    check("model_data0", data0, e_data[0]);
    check("model_data1", data1, e_data[1]);
    check("model_le0", le0, e_le);
    check("model_le1", le1, e_le);
    check("model_fe0", fe0, e_fe);
    check("model_fe1", fe1, e_fe);
    check("model_serr0", se0, e_serr);
    check("model_serr1", se1, e_serr);
    check("model_rdy0", rdy0, e_rdy);
    check("model_rdy1", rdy1, e_rdy);
    if (dv0) begin
      if (exp_q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_word0: got %0h with no word expected", {le0, fe0, data0});
      end else check("sb_word0", {le0, fe0, data0}, exp_q0.pop_front());
    end
    if (dv1) begin
      if (exp_q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_word1: got %0h with no word expected", {le1, fe1, data1});
      end else check("sb_word1", {le1, fe1, data1}, exp_q1.pop_front());
    end
    if (cnt_en) begin
      if (!rdy0) rdy_low_cnt++;
      if (dv0 || dv1) dv_cnt++;
      if (se0) serr_cnt0++;
      if (se1) serr_cnt1++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    rgb_valid = 1'b0;
    rgb_sof   = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pix(input logic [23:0] p, input bit sof);
    bit acc;
    int guard;
    acc = 0;
    guard = 0;
    rgb_in = p;
    rgb_sof = sof;
    rgb_valid = 1'b1;
    while (!acc && guard < 64) begin
      @(negedge clk);
      acc = rdy0;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) begin
      checks++; failures++;
      $display("FAIL accept_timeout: got no rgb_ready within %0d cycles, expected accept", guard);
    end
    rgb_valid = 1'b0;
    rgb_sof = 1'b0;
  endtask

  task automatic send_flat_frame(input bit stall);
    for (int i = 0; i < 2 * LL * FL; i++) begin
      if (stall) idle($urandom_range(0, 2));
      send_pix(24'h112233, i == 0);
    end
  endtask

  task automatic push_flat_frame();
    for (int k = 0; k < 8; k++)
      push_exp(k < 4 ? 16'h2233 : 16'h1122, k < 4 ? 16'hDD33 : 16'hEEDD, k == 3 || k == 7, k == 7);
  endtask

  task automatic send_ramp_frame();
    for (int i = 0; i < 2 * LL * FL; i++) begin
      logic [7:0] v;
      v = 8'(i);
      send_pix({v, v, v}, i == 0);
    end
  endtask

  task automatic push_ramp_frame();
    logic [15:0] r0[8];
    logic [15:0] r1[8];
    r0 = '{16'h0001, 16'h0203, 16'h0405, 16'h0607, 16'h0809, 16'h0A0B, 16'h0C0D, 16'h0E0F};
    r1 = '{16'hFF01, 16'hFD03, 16'hFB05, 16'hF907, 16'hF7F6, 16'hF5F4, 16'hF3F2, 16'hF1F0};
    for (int k = 0; k < 8; k++) push_exp(r0[k], r1[k], k == 3 || k == 7, k == 7);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data0"}, data0, 16'h0);
    check({tag, "_data1"}, data1, 16'h0);
    check({tag, "_dv"}, {dv0, dv1}, 2'b00);
    check({tag, "_le"}, {le0, le1}, 2'b00);
    check({tag, "_fe"}, {fe0, fe1}, 2'b00);
    check({tag, "_serr"}, {se0, se1}, 2'b00);
    check({tag, "_rdy"}, {rdy0, rdy1}, 2'b11);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    #3;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Reset mid-line just after a word was emitted
    push_exp(16'h2233, 16'hDD33, 1'b0, 1'b0);
    send_pix(24'h112233, 1'b1);
    send_pix(24'h112233, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    // Pixels without sof are discarded
    dv_cnt = 0;
    cnt_en = 1;
    for (int i = 0; i < 8; i++) send_pix(24'h445566, 1'b0);
    idle(3);
    cnt_en = 0;
    check("nosof_dv_count", dv_cnt, 0);

    // Continuous flat frame
    rdy_low_cnt = 0;
    cnt_en = 1;
    push_flat_frame();
    send_flat_frame(1'b0);
    idle(GAP + 3);
    cnt_en = 0;
    check("flat_rdy_low_cycles", rdy_low_cnt, 2 * GAP);

    // Column ramp
    push_ramp_frame();
    send_ramp_frame();
    idle(GAP + 3);

    // Stalled flat frame gives the same 8 words
    dv_cnt = 0;
    cnt_en = 1;
    push_flat_frame();
    send_flat_frame(1'b1);
    idle(GAP + 3);
    cnt_en = 0;
    check("stall_word_count", dv_cnt, 8);

    // sof re-asserted at column 3 of row 0
    serr_cnt0 = 0;
    serr_cnt1 = 0;
    cnt_en = 1;
    push_exp(16'h1011, 16'hEF11, 1'b0, 1'b0);
    push_ramp_frame();
    send_pix(24'h101010, 1'b1);
    send_pix(24'h111111, 1'b0);
    send_pix(24'h121212, 1'b0);
    send_ramp_frame();
    idle(GAP + 3);
    cnt_en = 0;
    check("sof_err_count0", serr_cnt0, 1);
    check("sof_err_count1", serr_cnt1, 1);

    check("sb_left0", exp_q0.size(), 0);
    check("sb_left1", exp_q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rgb2raw_8.md
# rgb2raw_8

Bayer mosaicing block: converts a one-pixel-per-cycle 24-bit RGB stream into the 8-bit RAW, two-pixels-per-word line format that the ISP demosaic stage consumes. It sits on the ISP input side as a synthetic RAW source for test patterns and loopback checks. It emits exactly LINE_LENGTH words per line with an enforced idle gap between lines, so its output can drive the demosaic input directly. The channel mapping is the exact inverse of the demosaic stage, so an RGB → RAW → RGB round trip reproduces flat-field colours.

## Interface
- LINE_LENGTH, 640: 16-bit words per line; pixels per line = 2*LINE_LENGTH
- FRAME_LINES, 480: lines per frame
- LINE_GAP, 4: cycles of forced idle (rgb_ready low, data_valid low) after each line; ≥1
- INVERT_RG, 1: 1 = bitwise-invert R and G before selection (cancels the downstream R/G inversion)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- rgb_in  in  24  pixel, {R[23:16], G[15:8], B[7:0]}
- rgb_valid  in  1  rgb_in valid
- rgb_sof  in  1  qualifies the first pixel of a frame
- rgb_ready  out  1  block accepts a pixel this cycle
- data_out  out  16  RAW word, {even-column byte, odd-column byte}
- data_valid  out  1  data_out valid, one-cycle pulse per word
- line_end  out  1  pulse with the last word of each line
- frame_end  out  1  pulse with the last word of a frame
- sof_err  out  1  pulse: rgb_sof accepted while in ACTIVE

## Operation
- Accept = rgb_valid & rgb_ready.
- rgb_ready is combinational: 1 in IDLE and ACTIVE, 0 in GAP.
- States:
  - IDLE: accepted pixels without rgb_sof are discarded. An accepted pixel with rgb_sof sets col=0 and row=0, is processed as column 0, and moves the FSM to ACTIVE.
  - ACTIVE: each accepted pixel is processed, then col increments.
  - GAP: a down-counter runs LINE_GAP cycles, then the FSM goes to ACTIVE, or to IDLE if the frame is complete.
- Byte select (R, G after optional inversion):
  - Even row: even col → G, odd col → B.
  - Odd row: even col → R, odd col → G.
- Even-column pixel: its selected byte is latched into the hold register.
- Odd-column pixel: next cycle, data_out = {hold, selected byte} and data_valid = 1.
- Line end: accepting pixel col = 2*LINE_LENGTH-1 produces the following:
  - line_end pulses with that word.
  - col wraps to 0 and row increments.
  - The FSM enters GAP.
  - If row was FRAME_LINES-1, frame_end also pulses, row wraps to 0, and GAP exits to IDLE.
- rgb_sof accepted in ACTIVE:
  - sof_err pulses one cycle later.
  - Any partial line and held byte are dropped; no word is emitted for them.
  - The pixel restarts the frame as row 0, col 0.
- rgb_sof in GAP cannot be accepted (rgb_ready is low).
- data_out holds its last value when data_valid is low.

## Timing
- Reset (asynchronous): FSM = IDLE, col = 0, row = 0, gap counter = 0, hold = 0.
- Output values during reset: data_out = 0, data_valid = 0, line_end = 0, frame_end = 0, sof_err = 0, rgb_ready = 1.
- Reset asserted mid-line or mid-frame aborts everything immediately; no further words are emitted until the next rgb_sof.
- Latency: 1 cycle from accepting an odd-column pixel to data_valid.
- line_end and frame_end are coincident with the data_valid of the final word.
- Continuous input: each line takes 2*LINE_LENGTH accept cycles plus LINE_GAP cycles with rgb_ready low. data_valid toggles at most every other cycle; the line gap is ≥ LINE_GAP+1 cycles of data_valid low.
- Input stalls (rgb_valid low) insert gaps and never alter counts or pairing.
- The first rgb_ready-low cycle is the cycle after the last pixel of a line is accepted.

## Test plan
Bench parameters: LINE_LENGTH=4, FRAME_LINES=2, LINE_GAP=3.

- Reset: assert rst_n=0 mid-line → all outputs are at their reset values immediately. Release, then send pixels without sof → no data_valid.
- INVERT_RG=0, continuous frame of 0x112233 with sof on the first pixel → row 0 gives 4 words 0x2233 and row 1 gives 4 words 0x1122. line_end is on the 4th and 8th words; frame_end is on the 8th only; rgb_ready is low exactly 3 cycles after each line.
- INVERT_RG=1, same stimulus → row 0 words = 0xDD33, row 1 words = 0xEEDD.
- Column ramp: pixel n = {n,n,n}, INVERT_RG=0 → row-0 words 0x0001, 0x0203, 0x0405, 0x0607.
- Random rgb_valid stalls during a frame → word sequence is identical to the unstalled run, 8 words total.
- rgb_sof re-asserted at col 3 of row 0 → sof_err pulses once, no word is emitted for cols 2–3, and the following 8 pixels produce the row-0 mapping.
